// File: rtl/idu_pkg.sv
// Shared opcode and immediate-type encodings for the npc decode stage.
package idu_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_U = 3'd2;
  localparam logic [2:0] IMM_S = 3'd3;
  localparam logic [2:0] IMM_B = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;
  localparam logic [2:0] IMM_Z = 3'd6;

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational opcode-to-immediate-type decode and immediate extraction.
// Define IDU_PIPE_ILLEGAL_EN to flag unrecognised encodings on 'illegal'.
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm_type = IMM_R;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:           imm_type = IMM_U;
      OPC_JAL:                      imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm_type = IMM_I;
      OPC_OPIMM32:                  imm_type = (XLEN == 64) ? IMM_I : IMM_R;
      OPC_STORE:                    imm_type = IMM_S;
      OPC_BRANCH:                   imm_type = IMM_B;
      OPC_SYSTEM:                   imm_type = inst[14] ? IMM_Z : IMM_I;
      default:                      imm_type = IMM_R;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm32 = {inst[31:12], 12'b0};
      IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z: imm32 = {27'b0, inst[19:15]};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries its sign in bit 31 (Z is positive).
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

`ifdef IDU_PIPE_ILLEGAL_EN
  // Only OP (and OP-32 on RV64) legitimately decode as R; anything else there is unknown.
  assign illegal = (imm_type == IMM_R) && (inst[6:0] != OPC_OP) &&
                   !((XLEN == 64) && (inst[6:0] == OPC_OP32));
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/idu_pipe.sv
// Registered instruction-decode stage: one pipeline register, valid/ready, flush, stall counter.
// Illegal-opcode detection is enabled by defining IDU_PIPE_ILLEGAL_EN.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        out_op,
  output logic [2:0]        out_func3,
  output logic [6:0]        out_func7,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_imm_type,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic            fire_in;
  logic            fire_out;
  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  assign in_ready = !out_valid || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  idu_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst    (in_inst),
    .imm_type(dec_type),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Flush wins over a simultaneous fire-in; data fields only change on an accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= '0;
      out_func3    <= '0;
      out_func7    <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_imm      <= '0;
      out_imm_type <= IMM_R;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_op       <= in_inst[6:0];
      out_func3    <= in_inst[14:12];
      out_func7    <= in_inst[31:25];
      out_rd       <= in_inst[11:7];
      out_rs1      <= in_inst[19:15];
      out_rs2      <= in_inst[24:20];
      out_imm      <= dec_imm;
      out_imm_type <= dec_type;
      out_illegal  <= dec_illegal;
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end

  // Back-pressure counter survives flush and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: an RV32 instance for the pipeline behaviour
// and an RV64 / 2-bit-counter instance for OP-IMM-32 and counter saturation.
module tb_idu_pipe;
  import idu_pkg::*;

`ifdef IDU_PIPE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  itype;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_func7;
  logic [2:0]  out_func3, out_imm_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] stall_cnt;

  logic        in_valid2, in_ready2, flush2, out_valid2, out_ready2, out_illegal2;
  logic [31:0] in_inst2;
  logic [63:0] in_pc2, out_pc2, out_imm2;
  logic [6:0]  out_op2, out_func72;
  logic [2:0]  out_func32, out_imm_type2;
  logic [4:0]  out_rd2, out_rs12, out_rs22;
  logic [1:0]  stall_cnt2;

  exp_t        sb[$];
  vec_t        vecs[13];
  int          testsRun = 0;
  int          failCount = 0;
  int          waited;
  logic [31:0] nextPc = 32'h8000_0000;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op), .out_func3(out_func3),
    .out_func7(out_func7), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  idu_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_inst(in_inst2), .in_pc(in_pc2), .flush(flush2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_pc(out_pc2), .out_op(out_op2), .out_func3(out_func32),
    .out_func7(out_func72), .out_rd(out_rd2), .out_rs1(out_rs12), .out_rs2(out_rs22),
    .out_imm(out_imm2), .out_imm_type(out_imm_type2), .out_illegal(out_illegal2),
    .stall_cnt(stall_cnt2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one instruction, waits (bounded) for acceptance, records the expected bundle.
  task automatic applyStimulus(input vec_t v, input logic fl, output int w);
    in_inst  = v.inst;
    in_pc    = nextPc;
    in_valid = 1'b1;
    flush    = fl;
    w        = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(0), 64'(1));
    else if (!fl) sb.push_back('{v, nextPc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    nextPc   = nextPc + 32'd4;
  endtask

  // Each bundle the execute side takes is compared against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_bundle", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        checkOutput("pc",      64'(out_pc),       64'(e.pc));
        checkOutput("op",      64'(out_op),       64'(e.v.inst[6:0]));
        checkOutput("func3",   64'(out_func3),    64'(e.v.inst[14:12]));
        checkOutput("func7",   64'(out_func7),    64'(e.v.inst[31:25]));
        checkOutput("rd",      64'(out_rd),       64'(e.v.rd));
        checkOutput("rs1",     64'(out_rs1),      64'(e.v.rs1));
        checkOutput("rs2",     64'(out_rs2),      64'(e.v.inst[24:20]));
        checkOutput("imm",     64'(out_imm),      64'(e.v.imm));
        checkOutput("imm_type", 64'(out_imm_type), 64'(e.v.itype));
        checkOutput("illegal", 64'(out_illegal),  64'(e.v.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'hFFF10093, 5'd1,  5'd2,  IMM_I, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h123452B7, 5'd5,  5'd8,  IMM_U, 32'h12345000, 1'b0};
    vecs[2]  = '{32'hFFDFF06F, 5'd0,  5'd31, IMM_J, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h00312423, 5'd8,  5'd2,  IMM_S, 32'h00000008, 1'b0};
    vecs[4]  = '{32'hFE000EE3, 5'd29, 5'd0,  IMM_B, 32'hFFFFFFFC, 1'b0};
    vecs[5]  = '{32'h002081B3, 5'd3,  5'd1,  IMM_R, 32'h00000000, 1'b0};
    vecs[6]  = '{32'h3002D073, 5'd0,  5'd5,  IMM_Z, 32'h00000005, 1'b0};
    vecs[7]  = '{32'h300110F3, 5'd1,  5'd2,  IMM_I, 32'h00000300, 1'b0};
    vecs[8]  = '{32'hFF80A283, 5'd5,  5'd1,  IMM_I, 32'hFFFFFFF8, 1'b0};
    vecs[9]  = '{32'h80000097, 5'd1,  5'd0,  IMM_U, 32'h80000000, 1'b0};
    vecs[10] = '{32'h004100E7, 5'd1,  5'd2,  IMM_I, 32'h00000004, 1'b0};
    vecs[11] = '{32'h00000000, 5'd0,  5'd0,  IMM_R, 32'h00000000, ILL};
    vecs[12] = '{32'hFFF1009B, 5'd1,  5'd2,  IMM_R, 32'h00000000, ILL};

    rst_n = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_inst2 = '0; in_pc2 = '0; flush2 = 1'b0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid),    64'(0));
    checkOutput("rst_in_ready",  64'(in_ready),     64'(1));
    checkOutput("rst_stall_cnt", 64'(stall_cnt),    64'(0));
    checkOutput("rst_imm",       64'(out_imm),      64'(0));
    checkOutput("rst_imm_type",  64'(out_imm_type), 64'(IMM_R));
    checkOutput("rst_illegal",   64'(out_illegal),  64'(0));
    checkOutput("rst_valid64",   64'(out_valid2),   64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(vecs[0], 1'b0, waited);
    checkOutput("latency_valid", 64'(out_valid), 64'(1));

    applyStimulus(vecs[1], 1'b0, waited);
    applyStimulus(vecs[2], 1'b0, waited);
    checkOutput("b2b_no_wait", 64'(waited), 64'(0));
    for (int i = 3; i < 13; i++) applyStimulus(vecs[i], 1'b0, waited);
    @(posedge clk);
    #1;

    // Three cycles of back-pressure with a second instruction waiting.
    out_ready = 1'b0;
    applyStimulus(vecs[3], 1'b0, waited);
    in_inst  = vecs[4].inst;
    in_pc    = nextPc;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(in_ready),  64'(0));
      checkOutput("stall_valid",    64'(out_valid), 64'(1));
      checkOutput("stall_imm_hold", 64'(out_imm),   64'(vecs[3].imm));
      checkOutput("stall_rd_hold",  64'(out_rd),    64'(vecs[3].rd));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_cnt_3",   64'(stall_cnt), 64'(3));
    checkOutput("release_ready", 64'(in_ready),  64'(1));
    sb.push_back('{vecs[4], nextPc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nextPc = nextPc + 32'd4;
    @(posedge clk);
    #1;

    applyStimulus(vecs[5], 1'b1, waited);
    checkOutput("flush_drop_valid", 64'(out_valid), 64'(0));

    out_ready = 1'b0;
    applyStimulus(vecs[6], 1'b0, waited);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    checkOutput("flush_held_valid",   64'(out_valid), 64'(0));
    checkOutput("stall_cnt_no_clear", 64'(stall_cnt), 64'(4));
    out_ready = 1'b1;

    // RV64 instance: OP-IMM-32 is legal and the 2-bit counter saturates.
    in_inst2 = 32'hFFF1009B; in_pc2 = 64'h1000; in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    checkOutput("x64_valid",    64'(out_valid2),    64'(1));
    checkOutput("x64_imm",      out_imm2,           64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("x64_imm_type", 64'(out_imm_type2), 64'(IMM_I));
    checkOutput("x64_illegal",  64'(out_illegal2),  64'(0));
    checkOutput("x64_rd",       64'(out_rd2),       64'(1));
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("sat_cnt_2", 64'(stall_cnt2), 64'(2));
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("sat_cnt_3", 64'(stall_cnt2), 64'(3));
    checkOutput("sat_in_ready", 64'(in_ready2), 64'(0));
    out_ready2 = 1'b1; in_inst2 = 32'h80000097; in_pc2 = 64'h1004; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    checkOutput("x64_u_imm",  out_imm2,           64'hFFFF_FFFF_8000_0000);
    checkOutput("x64_u_type", 64'(out_imm_type2), 64'(IMM_U));
    checkOutput("x64_u_pc",   out_pc2,            64'h1004);

    // Asynchronous reset while a bundle is held.
    out_ready = 1'b0;
    applyStimulus(vecs[0], 1'b0, waited);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid",     64'(out_valid), 64'(0));
    checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'(0));
    checkOutput("arst_in_ready",  64'(in_ready),  64'(1));
    checkOutput("arst_imm",       64'(out_imm),   64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(vecs[1], 1'b0, waited);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
# idu_pipe

Registered, parametrised instruction-decode stage for the npc core. It sits between fetch and execute and accepts one instruction plus PC per valid/ready handshake. It derives the immediate type from the opcode itself, with no external ExtOP. It presents a registered decode bundle with one-cycle latency, and supports flush, optional illegal-opcode detection and a saturating stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 (64 enables OP-IMM-32/OP-32).
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_op  out  7  inst[6:0].
- out_func3  out  3  inst[14:12].
- out_func7  out  7  inst[31:25].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_imm_type  out  3  R=0, I=1, U=2, S=3, B=4, J=5, Z=6.
- out_illegal  out  1  unrecognised encoding.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Fire-in when in_valid and in_ready. Fire-out when out_valid and out_ready.
- in_ready = !out_valid || out_ready. This is a single pipeline register with no skid entry.
- On fire-in, decode in_inst combinationally and register all out_* fields. out_valid is set.
- If fire-out occurs without fire-in, out_valid is cleared. Data fields hold their last value.
- Type selection by opcode:
  - 0110111/0010111 give U.
  - 1101111 gives J.
  - 1100111, 0000011 and 0010011 give I.
  - 0011011 gives I (XLEN=64 only).
  - 0100011 gives S. 1100011 gives B.
  - 0110011 gives R. 0111011 gives R (XLEN=64 only).
  - 1110011 gives Z when func3[2]=1, otherwise I.
- Immediates are built from standard RV bit slicing and sign-extended from inst[31] to XLEN.
  - Z: rs1 field zero-extended.
  - R: 0.
  - U: inst[31:12]<<12, sign-extended to XLEN.
- Flush has priority over everything. Next cycle out_valid=0, and a simultaneous fire-in is dropped. in_ready follows its normal equation during flush.
- stall_cnt increments each cycle with out_valid && !out_ready. It saturates at all-ones and is not cleared by flush.

## Timing
- Latency is exactly 1 cycle from fire-in to out_valid.
- Throughput is 1 instruction per cycle while out_ready=1.
- While out_valid && !out_ready, all out_* fields hold stable.
- Reset values: out_valid=0, stall_cnt=0, and all data outputs 0, so out_imm_type=R and out_illegal=0. in_ready=1 after reset.
- Reset asserted mid-operation clears out_valid and stall_cnt immediately, without waiting for clk. The held instruction is lost.

## Configuration
- IDU_PIPE_ILLEGAL_EN defined: out_illegal=1 in any of these cases:
  - inst[1:0]≠2'b11.
  - Opcode not in the table above.
  - XLEN=32 with opcode 0011011/0111011.
- An illegal instruction still occupies the stage and handshakes normally. It has imm=0 and type=R.
- Undefined: out_illegal tied 0, and unknown opcodes decode as type R with imm=0.

## Structure
- Package idu_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_OP32, OPC_SYSTEM).
  - the 3-bit imm-type encoding constants.
- Sub-module idu_imm_gen is purely combinational. Inputs: inst and XLEN. Outputs: imm_type, imm, illegal. idu_pipe instantiates it and owns the register, handshake, flush and counter.

## Test plan
- XLEN=32, in 0xFFF10093 (addi x1,x2,-1) -> one cycle later out_valid=1, rd=1, rs1=2, type=I, imm=0xFFFFFFFF.
- Back-to-back 0x123452B7 then 0xFFDFF06F with out_ready=1 -> imm 0x12345000 (U, rd=5), then 0xFFFFFFFC (J); one instruction per cycle.
- out_ready=0 for 3 cycles with a second instruction pending -> in_ready=0, outputs frozen, stall_cnt=3. Second instruction accepted the cycle after out_ready=1.
- flush asserted in the same cycle as fire-in -> out_valid=0 next cycle, no bundle emitted. Repeat with CNT_W=2 and 5 stall cycles -> stall_cnt=3 (saturated).
- Illegal encodings:
  - In 0x00000000 -> out_illegal=1 with IDU_PIPE_ILLEGAL_EN, 0 without.
  - XLEN=64, in 0xFFF1009B -> legal, imm=64'hFFFFFFFFFFFFFFFF.
  - XLEN=32, in 0xFFF1009B -> illegal.
- rst_n driven low asynchronously while out_valid=1 -> out_valid=0 and stall_cnt=0 before the next clk edge. After release, the first accepted instruction decodes correctly.
